// File: rtl/console_mux.sv
// Registered N-to-M GPIO crossbar: each output lane picks one gpio by index, gated by a per-lane enable.
// Latency 1 cycle (3 from gpios when INPUT_SYNC_EN is defined); no backpressure, inputs sampled every cycle.
module console_mux #(
    parameter int INPUT_COUNT  = 4,
    parameter int OUTPUT_COUNT = 4,
    parameter int SEL_W        = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [INPUT_COUNT-1:0]          gpios,
    input  logic [OUTPUT_COUNT*SEL_W-1:0]   selectors,
    input  logic [OUTPUT_COUNT-1:0]         enabled,
    output logic [OUTPUT_COUNT-1:0]         out
);

    logic [INPUT_COUNT-1:0]  gpios_s;
    logic [OUTPUT_COUNT-1:0] out_d;
    logic [OUTPUT_COUNT-1:0] out_q;
    logic [SEL_W-1:0]        lane_sel;

`ifdef INPUT_SYNC_EN
    logic [INPUT_COUNT-1:0] gpios_meta_d;
    logic [INPUT_COUNT-1:0] gpios_meta_q;
    logic [INPUT_COUNT-1:0] gpios_sync_d;
    logic [INPUT_COUNT-1:0] gpios_sync_q;

    always_comb begin
        gpios_meta_d = gpios;
        gpios_sync_d = gpios_meta_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gpios_meta_q <= '0;
            gpios_sync_q <= '0;
        end else begin
            gpios_meta_q <= gpios_meta_d;
            gpios_sync_q <= gpios_sync_d;
        end
    end

    assign gpios_s = gpios_sync_q;
`else
    assign gpios_s = gpios;
`endif

    // Matching by equality against each valid index means out-of-range or
    // unknown selectors never hit a branch, so the lane falls back to 0.
    always_comb begin
        out_d    = '0;
        lane_sel = '0;
        for (int j = 0; j < OUTPUT_COUNT; j++) begin
            lane_sel = selectors[j*SEL_W +: SEL_W];
            if (enabled[j] == 1'b1) begin
                for (int k = 0; k < INPUT_COUNT; k++) begin
                    if (lane_sel == SEL_W'(k)) begin
                        out_d[j] = gpios_s[k];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_console_mux.sv
// Directed self-checking bench for console_mux (default parameters, either build).
module tb_console_mux;

`ifdef INPUT_SYNC_EN
    localparam int GL = 3;
`else
    localparam int GL = 1;
`endif

    logic        clk;
    logic        rst;
    logic [3:0]  gpios;
    logic [15:0] selectors;
    logic [3:0]  enabled;
    logic [3:0]  out;

    int n_checks;
    int n_fail;

    console_mux #(.INPUT_COUNT(4), .OUTPUT_COUNT(4), .SEL_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .gpios     (gpios),
        .selectors (selectors),
        .enabled   (enabled),
        .out       (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [15:0] pack_sel(input logic [3:0] s3, input logic [3:0] s2,
                                             input logic [3:0] s1, input logic [3:0] s0);
        return {s3, s2, s1, s0};
    endfunction

    task automatic test_reset();
        rst       = 1'b1;
        gpios     = 4'b1111;
        enabled   = 4'b1111;
        selectors = pack_sel(4'd3, 4'd2, 4'd1, 4'd0);
        #1;
        n_checks++;
        if (out !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_initial: out=%b expected=%b", out, 4'b0000);
        end
        tick(3);
        n_checks++;
        if (out !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_held: out=%b expected=%b", out, 4'b0000);
        end
        rst = 1'b0;
        tick(GL);
        n_checks++;
        if (out !== 4'b1111) begin
            n_fail++;
            $display("FAIL reset_release: out=%b expected=%b", out, 4'b1111);
        end
    endtask

    task automatic test_sweep();
        logic [3:0] g;
        logic [3:0] s0;
        logic       exp0;
        logic       exp1;
        enabled = 4'b0011;
        for (int v = 0; v < 16; v++) begin
            g         = 4'(v);
            s0        = 4'(v % 4);
            gpios     = g;
            selectors = pack_sel(4'd0, 4'd0, 4'd1, s0);
            exp0      = g[s0[1:0]];
            exp1      = g[1];
            tick(GL);
            n_checks++;
            if (out !== {2'b00, exp1, exp0}) begin
                n_fail++;
                $display("FAIL sweep g=%b sel0=%0d: out=%b expected=%b",
                         g, s0, out, {2'b00, exp1, exp0});
            end
        end
    endtask

    task automatic test_selector_latency();
        gpios     = 4'b0101;
        enabled   = 4'b1111;
        selectors = pack_sel(4'd0, 4'd0, 4'd0, 4'd0);
        tick(GL);
        n_checks++;
        if (out !== 4'b1111) begin
            n_fail++;
            $display("FAIL sel_lat_base: out=%b expected=%b", out, 4'b1111);
        end
        selectors = pack_sel(4'd1, 4'd1, 4'd1, 4'd1);
        tick(1);
        n_checks++;
        if (out !== 4'b0000) begin
            n_fail++;
            $display("FAIL sel_lat_sel1: out=%b expected=%b", out, 4'b0000);
        end
        selectors = pack_sel(4'd2, 4'd3, 4'd2, 4'd0);
        tick(1);
        n_checks++;
        if (out !== 4'b1011) begin
            n_fail++;
            $display("FAIL sel_lat_mixed: out=%b expected=%b", out, 4'b1011);
        end
        selectors = pack_sel(4'd3, 4'd3, 4'd3, 4'd3);
        tick(1);
        n_checks++;
        if (out !== 4'b0000) begin
            n_fail++;
            $display("FAIL sel_lat_sel3: out=%b expected=%b", out, 4'b0000);
        end
    endtask

    task automatic test_disable();
        gpios     = 4'b0011;
        enabled   = 4'b0011;
        selectors = pack_sel(4'd0, 4'd0, 4'd1, 4'd0);
        tick(GL);
        n_checks++;
        if (out !== 4'b0011) begin
            n_fail++;
            $display("FAIL disable_base: out=%b expected=%b", out, 4'b0011);
        end
        enabled = 4'b0001;
        tick(1);
        n_checks++;
        if (out !== 4'b0001) begin
            n_fail++;
            $display("FAIL disable_lane1: out=%b expected=%b", out, 4'b0001);
        end
        gpios = 4'b0010;
        tick(GL);
        n_checks++;
        if (out !== 4'b0000) begin
            n_fail++;
            $display("FAIL disable_track_lo: out=%b expected=%b", out, 4'b0000);
        end
        gpios = 4'b0011;
        tick(GL);
        n_checks++;
        if (out !== 4'b0001) begin
            n_fail++;
            $display("FAIL disable_track_hi: out=%b expected=%b", out, 4'b0001);
        end
    endtask

    task automatic test_out_of_range();
        gpios     = 4'b1111;
        enabled   = 4'b0001;
        selectors = pack_sel(4'd0, 4'd0, 4'd0, 4'd3);
        tick(GL);
        n_checks++;
        if (out !== 4'b0001) begin
            n_fail++;
            $display("FAIL oor_sel3: out=%b expected=%b", out, 4'b0001);
        end
        selectors = pack_sel(4'd0, 4'd0, 4'd0, 4'd4);
        tick(1);
        n_checks++;
        if (out !== 4'b0000) begin
            n_fail++;
            $display("FAIL oor_sel4: out=%b expected=%b", out, 4'b0000);
        end
        selectors = pack_sel(4'd0, 4'd0, 4'd0, 4'd15);
        tick(1);
        n_checks++;
        if (out !== 4'b0000) begin
            n_fail++;
            $display("FAIL oor_sel15: out=%b expected=%b", out, 4'b0000);
        end
    endtask

    task automatic test_fanout();
        gpios     = 4'b1011;
        enabled   = 4'b1111;
        selectors = pack_sel(4'd2, 4'd2, 4'd2, 4'd2);
        tick(GL);
        n_checks++;
        if (out !== 4'b0000) begin
            n_fail++;
            $display("FAIL fanout_1011_pre: out=%b expected=%b", out, 4'b0000);
        end
        gpios = 4'b0100;
        tick(GL);
        n_checks++;
        if (out !== 4'b1111) begin
            n_fail++;
            $display("FAIL fanout_0100: out=%b expected=%b", out, 4'b1111);
        end
        gpios = 4'b1011;
        tick(GL);
        n_checks++;
        if (out !== 4'b0000) begin
            n_fail++;
            $display("FAIL fanout_1011: out=%b expected=%b", out, 4'b0000);
        end
        gpios = 4'b0100;
        tick(GL);
    endtask

    task automatic test_async_reset();
        n_checks++;
        if (out !== 4'b1111) begin
            n_fail++;
            $display("FAIL async_pre: out=%b expected=%b", out, 4'b1111);
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (out !== 4'b0000) begin
            n_fail++;
            $display("FAIL async_mid_cycle: out=%b expected=%b", out, 4'b0000);
        end
        tick(2);
        n_checks++;
        if (out !== 4'b0000) begin
            n_fail++;
            $display("FAIL async_held: out=%b expected=%b", out, 4'b0000);
        end
        rst = 1'b0;
        tick(GL);
        n_checks++;
        if (out !== 4'b1111) begin
            n_fail++;
            $display("FAIL async_resume: out=%b expected=%b", out, 4'b1111);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_sweep();
        test_selector_latency();
        test_disable();
        test_out_of_range();
        test_fanout();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
